// File: rtl/cordic_pkg.sv
// ============================================================================
// Module      : cordic_pkg
// Description : Shared constants and FSM state type for the CORDIC angle sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

  localparam int FRAC_BITS = 24;
  // 2*pi in Q.24 radians
  localparam int TWO_PI = 105414357;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } sweep_state_t;

endpackage

`default_nettype wire

// File: rtl/cordic_angle_wrap_add.sv
// ============================================================================
// Module      : cordic_angle_wrap_add
// Description : Combinational modulo-TWO_PI adder for angles in [0, TWO_PI).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_angle_wrap_add
  import cordic_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  output logic [n-1:0] sum_o
);

  localparam logic [n:0]   c_two_pi_w = (n+1)'(TWO_PI);
  localparam logic [n-1:0] c_two_pi_n = n'(TWO_PI);

  logic [n:0]   w_sum;
  logic [n-1:0] w_diff;

  // Carry bit keeps the sum exact; the wrapped result always fits in n bits.
  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff = w_sum[n-1:0] - c_two_pi_n;
  assign sum_o  = (w_sum >= c_two_pi_w) ? w_diff : w_sum[n-1:0];

endmodule

`default_nettype wire

// File: rtl/cordic_angle_sweep.sv
// ============================================================================
// Module      : cordic_angle_sweep
// Description : Steps a downstream CORDIC sin/cos core through an angle sweep,
//               holding each angle for HOLD_CYCLES enable cycles.
//               Optional macro SWEEP_CHIRP_EN adds a latched step_delta to the
//               step on every angle advance (linear chirp).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_angle_sweep
  import cordic_pkg::*;
#(
  parameter int n           = 32,
  parameter int HOLD_CYCLES = 40
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic [n-1:0] start_angle,
  input  logic [n-1:0] step_in,
  input  logic [15:0]  num_points,
`ifdef SWEEP_CHIRP_EN
  input  logic [n-1:0] step_delta,
`endif
  output logic [n-1:0] angle_out,
  output logic         cordic_clear,
  output logic         cordic_enable,
  output logic         sample_valid,
  output logic         busy,
  output logic         cfg_err
);

  localparam logic [n-1:0] c_two_pi    = n'(TWO_PI);
  localparam logic [7:0]   c_hold_last = 8'(HOLD_CYCLES - 1);

  sweep_state_t state_q, state_d;
  logic [n-1:0] angle_q, angle_d;
  logic [n-1:0] step_q, step_d;
  logic [15:0]  pts_q, pts_d;
  logic [7:0]   hold_q, hold_d;
  logic         stop_q, stop_d;
  logic         cfg_err_q, cfg_err_d;

  logic [n-1:0] w_next_angle;
  logic [n-1:0] w_next_step;
  logic         w_cfg_ok;
  logic         w_last;
  logic         w_pts_done;
  logic         w_stop_pend;

  cordic_angle_wrap_add #(
    .n (n)
  ) u_wrap (
    .a_i   (angle_q),
    .b_i   (step_q),
    .sum_o (w_next_angle)
  );

  assign w_cfg_ok    = !start_angle[n-1] && (start_angle < c_two_pi) &&
                       !step_in[n-1]     && (step_in < c_two_pi);
  assign w_last      = (state_q == RUN) && (hold_q == c_hold_last);
  assign w_pts_done  = (pts_q == 16'd1);
  assign w_stop_pend = stop_q | stop;

`ifdef SWEEP_CHIRP_EN
  localparam logic [n:0]   c_step_max_w = (n+1)'(TWO_PI - 1);
  localparam logic [n-1:0] c_step_max   = n'(TWO_PI - 1);

  logic [n-1:0] delta_q, delta_d;
  logic [n+1:0] w_step_sum;

  // Signed delta; the step is clamped to [0, TWO_PI-1] so the adder stays valid.
  assign w_step_sum = {2'b00, step_q} + {{2{delta_q[n-1]}}, delta_q};

  always_comb begin
    w_next_step = w_step_sum[n-1:0];
    if (w_step_sum[n+1]) begin
      w_next_step = '0;
    end else if (w_step_sum[n:0] > c_step_max_w) begin
      w_next_step = c_step_max;
    end
  end
`else
  assign w_next_step = step_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      angle_q   <= '0;
      step_q    <= '0;
      pts_q     <= '0;
      hold_q    <= '0;
      stop_q    <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef SWEEP_CHIRP_EN
      delta_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      step_q    <= step_d;
      pts_q     <= pts_d;
      hold_q    <= hold_d;
      stop_q    <= stop_d;
      cfg_err_q <= cfg_err_d;
`ifdef SWEEP_CHIRP_EN
      delta_q   <= delta_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    step_d    = step_q;
    pts_d     = pts_q;
    hold_d    = hold_q;
    stop_d    = stop_q;
    cfg_err_d = 1'b0;
`ifdef SWEEP_CHIRP_EN
    delta_d   = delta_q;
`endif
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        hold_d = '0;
        if (start && !stop) begin
          if (w_cfg_ok) begin
            state_d = CLEAR;
            angle_d = start_angle;
            step_d  = step_in;
            pts_d   = num_points;
`ifdef SWEEP_CHIRP_EN
            delta_d = step_delta;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        hold_d  = '0;
        state_d = RUN;
        if (stop) stop_d = 1'b1;
      end
      RUN: begin
        if (stop) stop_d = 1'b1;
        if (w_last) begin
          if (pts_q != 16'd0) pts_d = pts_q - 16'd1;
          // The angle only advances when another point follows, so IDLE keeps
          // showing the last angle that was actually sampled.
          if (w_pts_done || w_stop_pend) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            hold_d  = '0;
          end else begin
            state_d = CLEAR;
            angle_d = w_next_angle;
            step_d  = w_next_step;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign angle_out     = angle_q;
  assign cordic_clear  = (state_q == CLEAR);
  assign cordic_enable = (state_q == RUN);
  assign sample_valid  = w_last;
  assign busy          = (state_q != IDLE);
  assign cfg_err       = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_angle_sweep.sv
// ============================================================================
// Module      : tb_cordic_angle_sweep
// Description : Self-checking bench for cordic_angle_sweep (SWEEP_CHIRP_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_angle_sweep;

  localparam longint TP   = 105414357;
  localparam int     HOLD = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] start_angle = '0;
  logic [31:0] step_in = '0;
  logic [31:0] step_delta = '0;
  logic [15:0] num_points = '0;

  logic [31:0] angle_out;
  logic        cordic_clear, cordic_enable, sample_valid, busy, cfg_err;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  cordic_angle_sweep #(
    .n           (32),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock         (clk),
    .reset         (rst_n),
    .start         (start),
    .stop          (stop),
    .start_angle   (start_angle),
    .step_in       (step_in),
    .num_points    (num_points),
`ifdef SWEEP_CHIRP_EN
    .step_delta    (step_delta),
`endif
    .angle_out     (angle_out),
    .cordic_clear  (cordic_clear),
    .cordic_enable (cordic_enable),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .cfg_err       (cfg_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    return (s >= 0) && (s < TP);
  endfunction

  function automatic longint clamp_step(input longint s);
    if (s < 0) return 0;
    if (s > TP - 1) return TP - 1;
    return s;
  endfunction

  // Behavioural model: a sweep is a sequence of points, each one clear cycle
  // (m_cyc==0) followed by HOLD enable cycles; sampled on the final one.
  bit     m_active, m_cont, m_stop, m_cfg;
  int     m_cyc, m_left;
  longint m_angle, m_step, m_delta;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_cont <= 1'b0; m_stop <= 1'b0; m_cfg <= 1'b0;
      m_cyc <= 0; m_left <= 0; m_angle <= 0; m_step <= 0; m_delta <= 0;
    end else if (!m_active) begin
      m_cfg  <= 1'b0;
      m_stop <= 1'b0;
      if (start && !stop) begin
        if (in_range(start_angle) && in_range(step_in)) begin
          m_active <= 1'b1;
          m_cyc    <= 0;
          m_angle  <= longint'(start_angle);
          m_step   <= longint'(step_in);
          m_left   <= int'(num_points);
          m_cont   <= (num_points == 16'd0);
`ifdef SWEEP_CHIRP_EN
          m_delta  <= longint'($signed(step_delta));
`else
          m_delta  <= 0;
`endif
        end else begin
          m_cfg <= 1'b1;
        end
      end
    end else begin
      m_cfg <= 1'b0;
      if (m_cyc < HOLD) begin
        m_cyc <= m_cyc + 1;
        if (stop) m_stop <= 1'b1;
      end else if ((!m_cont && m_left == 1) || m_stop || stop) begin
        m_active <= 1'b0;
        m_stop   <= 1'b0;
        m_cyc    <= 0;
      end else begin
        m_cyc   <= 0;
        m_angle <= (m_angle + m_step) % TP;
        m_step  <= clamp_step(m_step + m_delta);
        if (!m_cont) m_left <= m_left - 1;
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("angle_out", angle_out, m_angle);
        chk("cordic_clear", cordic_clear, m_active && m_cyc == 0);
        chk("cordic_enable", cordic_enable, m_active && m_cyc > 0);
        chk("sample_valid", sample_valid, m_active && m_cyc == HOLD);
        chk("busy", busy, m_active);
        chk("cfg_err", cfg_err, m_cfg);
      end
    end
  end

  longint q_ang[$];
  int     q_cyc[$];
  int     n_clr = 0;
  int     cyc_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (rst_n && sample_valid) begin
        q_ang.push_back(longint'(angle_out));
        q_cyc.push_back(cyc_cnt);
      end
      if (rst_n && cordic_clear) n_clr++;
    end
  end

  task automatic pulse_start(input logic [31:0] sa, input logic [31:0] st,
                             input logic [15:0] np, input logic with_stop);
    @(negedge clk);
    start_angle = sa;
    step_in     = st;
    num_points  = np;
    stop        = with_stop;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic chk_angle(input string nm, input int idx, input longint exp);
    if (q_ang.size() > idx) chk(nm, q_ang[idx], exp);
    else chk({nm, "_missing"}, q_ang.size(), idx + 1);
  endtask

  int base, c0, k;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_angle", angle_out, 0);
    chk("rst_clear", cordic_clear, 0);
    chk("rst_enable", cordic_enable, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // 45-degree sweep, 8 points
    base = q_ang.size();
    pulse_start(32'd0, 32'd13176795, 16'd8, 1'b0);
    chk("first_clear", cordic_clear, 1);
    chk("first_angle", angle_out, 0);
    chk("first_busy", busy, 1);
    wait_idle(8 * 41 + 20, "sweep45_timeout");
    chk("sweep45_count", q_ang.size() - base, 8);
    for (int i = 0; i < 8; i++) chk_angle("sweep45_angle", base + i, longint'(i) * 13176795);
    chk_angle("sweep45_last", base + 7, 92237565);
    for (int i = 1; i < 8; i++)
      if (q_cyc.size() > base + i) chk("sweep45_period", q_cyc[base+i] - q_cyc[base+i-1], 41);
    chk("hold_last_angle", angle_out, 92237565);

    // wrap past TWO_PI; a start while busy is ignored
    base = q_ang.size();
    pulse_start(32'd102486144, 32'd5856428, 16'd2, 1'b0);
    repeat (10) @(negedge clk);
    start_angle = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(2 * 41 + 20, "wrap_timeout");
    chk("wrap_count", q_ang.size() - base, 2);
    chk_angle("wrap_angle0", base, 102486144);
    chk_angle("wrap_angle1", base + 1, 2928215);
    chk("wrap_hold_angle", angle_out, 2928215);

    // rejected configurations
    pulse_start(32'd0, 32'd105414357, 16'd4, 1'b0);
    chk("rej_step_cfg_err", cfg_err, 1);
    chk("rej_step_busy", busy, 0);
    @(negedge clk);
    chk("rej_step_pulse_end", cfg_err, 0);
    chk("rej_step_busy2", busy, 0);
    pulse_start(32'hFFFF_FF00, 32'd100, 16'd4, 1'b0);
    chk("rej_neg_cfg_err", cfg_err, 1);
    chk("rej_neg_busy", busy, 0);

    // start together with stop: stop wins silently
    pulse_start(32'd0, 32'd100, 16'd4, 1'b1);
    chk("startstop_busy", busy, 0);
    chk("startstop_cfg_err", cfg_err, 0);

    // continuous sweep stopped during the third point
    base = q_ang.size();
    c0   = n_clr;
    pulse_start(32'd1000, 32'd13176795, 16'd0, 1'b0);
    k = 0;
    while (q_ang.size() < base + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("cont_two_points", q_ang.size() - base, 2);
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(100, "cont_timeout");
    chk("cont_count", q_ang.size() - base, 3);
    chk("cont_clears", n_clr - c0, 3);
    chk_angle("cont_angle2", base + 2, 26354590);

    // asynchronous reset mid-RUN
    base = q_ang.size();
    pulse_start(32'd0, 32'd13176795, 16'd8, 1'b0);
    repeat (20) @(negedge clk);
    chk("pre_rst_enable", cordic_enable, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_angle", angle_out, 0);
    chk("async_clear", cordic_clear, 0);
    chk("async_enable", cordic_enable, 0);
    chk("async_valid", sample_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_cfg_err", cfg_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_resume_busy", busy, 0);
    chk("no_valid_after_rst", q_ang.size() - base, 0);
    pulse_start(32'd5856428, 32'd13176795, 16'd2, 1'b0);
    chk("restart_angle", angle_out, 5856428);
    wait_idle(2 * 41 + 20, "restart_timeout");
    chk_angle("restart_a0", base, 5856428);
    chk_angle("restart_a1", base + 1, 19033223);

`ifdef SWEEP_CHIRP_EN
    base = q_ang.size();
    step_delta = 32'd1000;
    pulse_start(32'd0, 32'd1000, 16'd4, 1'b0);
    step_delta = 32'd0;
    wait_idle(4 * 41 + 20, "chirp_timeout");
    chk("chirp_count", q_ang.size() - base, 4);
    chk_angle("chirp_a0", base, 0);
    chk_angle("chirp_a1", base + 1, 1000);
    chk_angle("chirp_a2", base + 2, 3000);
    chk_angle("chirp_a3", base + 3, 6000);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cordic_angle_sweep.md
CORDIC_ANGLE_SWEEP -- requirements
Module: cordic_angle_sweep

Interface
REQ-001 SHALL have parameter n, default 32: angle word width, signed, radians, Q(n-24).24.
REQ-002 SHALL have parameter HOLD_CYCLES, default 40: enable cycles per angle so the downstream sin/cos stage converges; legal range 1..255.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin a sweep; sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1 bit: end the sweep after the current angle completes.
REQ-007 SHALL have port start_angle, input, n bits: first angle.
REQ-008 SHALL have port step_in, input, n bits: angle increment.
REQ-009 SHALL have port num_points, input, 16 bits: angles per sweep; 0 means continuous.
REQ-010 SHALL have port angle_out, output, n bits: drives the downstream angle_in.
REQ-011 SHALL have port cordic_clear, output, 1 bit: active-high one-cycle pulse to the downstream reset.
REQ-012 SHALL have port cordic_enable, output, 1 bit: drives the downstream enable.
REQ-013 SHALL have port sample_valid, output, 1 bit: one-cycle pulse meaning the downstream cos/sin outputs are settled for angle_out.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-016 FSM SHALL have states IDLE, CLEAR and RUN.
REQ-017 IDLE->CLEAR when start=1, stop=0, and start_angle and step_in are both in [0, TWO_PI); start_angle, step_in and num_points are latched on that edge.
REQ-018 If either value is outside [0, TWO_PI), start SHALL be rejected: state stays IDLE and cfg_err pulses.
REQ-019 If start and stop are both high in IDLE, stop SHALL win: no sweep, no cfg_err.
REQ-020 CLEAR SHALL last one cycle, with cordic_clear=1, cordic_enable=0 and angle_out already holding the new angle.
REQ-021 CLEAR->RUN unconditionally.
REQ-022 In RUN, cordic_enable SHALL be 1 for exactly HOLD_CYCLES cycles, counted by an 8-bit hold counter.
REQ-023 sample_valid SHALL pulse on the last RUN cycle.
REQ-024 Per-angle period SHALL be HOLD_CYCLES+1 cycles.
REQ-025 First cordic_clear SHALL occur one cycle after start is sampled.
REQ-026 On the last RUN cycle, the next angle SHALL be angle+step; if the sum is >= TWO_PI, TWO_PI is subtracted (single conditional subtract, computed on n+1 bits, no overflow).
REQ-027 On the last RUN cycle, a 16-bit point counter SHALL decrement when num_points != 0.
REQ-028 Leaving RUN: go to IDLE if the point counter reaches 0 or stop is pending; otherwise go to CLEAR.
REQ-029 stop SHALL be latched whenever busy; it is cleared on entry to IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 angle_out SHALL hold its last value in IDLE.

Reset
REQ-032 Asserting reset (low) SHALL asynchronously force: state IDLE, angle_out=0, cordic_clear=0, cordic_enable=0, sample_valid=0, busy=0, cfg_err=0, both counters 0, stop latch 0.
REQ-033 Reset mid-sweep SHALL abandon the sweep with no sample_valid.
REQ-034 Operation SHALL resume only on a new start after reset is deasserted.

Configuration
REQ-035 With macro SWEEP_CHIRP_EN defined, an input step_delta (n bits) SHALL be added to the step on every angle advance (linear chirp).
REQ-036 Under SWEEP_CHIRP_EN, the step SHALL saturate at TWO_PI-1.
REQ-037 Under SWEEP_CHIRP_EN, step_delta SHALL be latched at start.
REQ-038 Without SWEEP_CHIRP_EN, the step_delta port SHALL be absent and the step stays constant.

Structure
REQ-039 Package cordic_pkg SHALL hold the fraction-bit constant (24) and TWO_PI = 105414357 (2*pi*2^24).
REQ-040 Package cordic_pkg SHALL hold the FSM state enum.
REQ-041 Sub-module cordic_angle_wrap_add SHALL implement the combinational modulo-TWO_PI adder.

Verification
REQ-042 start_angle=0, step=13176795 (45 deg), num_points=8, HOLD=40 -> angles 0, 13176795, ... 92237565; 8 sample_valid pulses 41 cycles apart; busy falls after the 8th.
REQ-043 start_angle=102486144 (350 deg), step=5856428 (20 deg), num_points=2 -> angles 102486144 then 2928215 (wrapped).
REQ-044 step_in=105414357 -> cfg_err pulse, busy stays 0.
REQ-045 num_points=0 with stop asserted during the 3rd RUN -> 3rd sample_valid occurs, then IDLE; no 4th cordic_clear.
REQ-046 reset low during RUN -> all outputs 0 immediately (asynchronous); the next start restarts from the new start_angle.
REQ-047 SWEEP_CHIRP_EN, start=0, step=1000, delta=1000, num_points=4 -> angles 0, 1000, 3000, 6000.
